// File: rtl/exc_sequencer_pkg.sv
// Shared CPU definitions for the exception-entry sequencer: state encoding,
// cause indices and the default vector table base.
package exc_sequencer_pkg;

  typedef enum logic [2:0] {
    EXC_IDLE    = 3'd0,
    EXC_CAPTURE = 3'd1,
    EXC_READ    = 3'd2,
    EXC_LOAD    = 3'd3,
    EXC_DONE    = 3'd4
  } exc_state_e;

  localparam int EXC_OPCODE   = 0;
  localparam int EXC_OVERFLOW = 1;
  localparam int EXC_DIVZERO  = 2;

  localparam logic [31:0] EXC_VEC_BASE = 32'd253;

endpackage

// File: rtl/exc_sequencer_prio_enc.sv
// Lowest-index-wins priority encoder: index 0 has the highest priority.
module exc_prio_enc #(
  parameter int NUM_CAUSES = 3,
  parameter int CAUSE_W    = (NUM_CAUSES > 1) ? $clog2(NUM_CAUSES) : 1
) (
  input  logic [NUM_CAUSES-1:0] req_i,
  output logic [CAUSE_W-1:0]    idx_o,
  output logic                  vld_o
);

  assign vld_o = |req_i;

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_CAUSES - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = CAUSE_W'(i);
    end
  end

endmodule

// File: rtl/exc_sequencer.sv
// Generic exception-entry sequencer: saves EPC, fetches the handler byte from
// the vector table and loads PC, servicing sticky pending causes by priority.
module exc_sequencer
  import exc_sequencer_pkg::*;
#(
  parameter int          NUM_CAUSES = 3,
  parameter int          CAUSE_W    = (NUM_CAUSES > 1) ? $clog2(NUM_CAUSES) : 1,
  parameter int          MEM_LAT    = 2,
  parameter logic [31:0] VEC_BASE   = EXC_VEC_BASE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CAUSES-1:0] exc_req,
  input  logic [31:0]           pc_in,
  input  logic [7:0]            mem_data_in,
  output logic [31:0]           mem_addr,
  output logic                  mem_read,
  output logic                  epc_write,
  output logic [31:0]           epc_data,
  output logic                  pc_write,
  output logic [31:0]           pc_out,
  output logic [CAUSE_W-1:0]    cause_out,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  exc_state_e            state_q, state_d;
  logic [NUM_CAUSES-1:0] pending_q, pending_d;
  logic [NUM_CAUSES-1:0] req_all;
  logic [NUM_CAUSES-1:0] clr_mask;
  logic [CAUSE_W-1:0]    cause_q, cause_d;
  logic [CAUSE_W-1:0]    enc_idx;
  logic                  enc_vld;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            byte_q, byte_d;

  // A request arriving in the same IDLE cycle is eligible immediately.
  assign req_all = pending_q | exc_req;

  exc_prio_enc #(
    .NUM_CAUSES (NUM_CAUSES),
    .CAUSE_W    (CAUSE_W)
  ) u_prio_enc (
    .req_i (req_all),
    .idx_o (enc_idx),
    .vld_o (enc_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EXC_IDLE;
      pending_q <= '0;
      cause_q   <= '0;
      cnt_q     <= '0;
      byte_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
      byte_q    <= byte_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    clr_mask = '0;
    case (state_q)
      EXC_IDLE: begin
        if (enc_vld) begin
          cause_d = enc_idx;
          state_d = EXC_CAPTURE;
        end
      end
      EXC_CAPTURE: begin
        clr_mask = NUM_CAUSES'(1) << cause_q;
        cnt_d    = CNT_W'(MEM_LAT - 1);
        state_d  = EXC_READ;
      end
      EXC_READ: begin
        // Memory data is only valid in the final read cycle.
        if (cnt_q == '0) begin
          byte_d  = mem_data_in;
          state_d = EXC_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      EXC_LOAD: state_d = EXC_DONE;
      EXC_DONE: state_d = EXC_IDLE;
      default:  state_d = EXC_IDLE;
    endcase
    // A fresh request for the cause being captured beats the clear.
    pending_d = (pending_q & ~clr_mask) | exc_req;
  end

  always_comb begin
    mem_addr  = '0;
    mem_read  = 1'b0;
    epc_write = 1'b0;
    epc_data  = '0;
    pc_write  = 1'b0;
    pc_out    = '0;
    done      = 1'b0;
    busy      = (state_q != EXC_IDLE);
    cause_out = cause_q;
    case (state_q)
      EXC_CAPTURE: begin
        epc_write = 1'b1;
        epc_data  = pc_in - 32'd4;
      end
      EXC_READ: begin
        mem_read = 1'b1;
        mem_addr = VEC_BASE + 32'(cause_q);
      end
      EXC_LOAD: begin
        pc_write = 1'b1;
        pc_out   = {24'b0, byte_q};
      end
      EXC_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: directed table, hand-written corner sequences and
// random requests checked against a service-schedule reference model.
module tb_exc_sequencer;

  localparam int L_A = 2;
  localparam int VB_A = 253;
  localparam int L_B = 4;

  logic        clk = 1'b0;
  logic        reset;
  // Default instance
  logic [2:0]  exc_req;
  logic [31:0] pc_in;
  logic [7:0]  mem_data_in;
  logic [31:0] mem_addr, epc_data, pc_out;
  logic        mem_read, epc_write, pc_write, busy, done;
  logic [1:0]  cause_out;
  // Five-cause instance with long memory latency
  logic [4:0]  b_req;
  logic [31:0] b_pc;
  logic [7:0]  b_mdata;
  logic [31:0] b_maddr, b_epcd, b_pco;
  logic        b_mrd, b_epcw, b_pcw, b_busy, b_done;
  logic [2:0]  b_cause;

  int checks = 0;
  int errors = 0;
  int rd_cnt_a = 0;
  int rd_cnt_b = 0;

  always #5 clk = ~clk;

  exc_sequencer dut (
    .clk(clk), .reset(reset), .exc_req(exc_req), .pc_in(pc_in),
    .mem_data_in(mem_data_in), .mem_addr(mem_addr), .mem_read(mem_read),
    .epc_write(epc_write), .epc_data(epc_data), .pc_write(pc_write),
    .pc_out(pc_out), .cause_out(cause_out), .busy(busy), .done(done)
  );

  exc_sequencer #(.NUM_CAUSES(5), .MEM_LAT(L_B), .VEC_BASE(32'h100)) dut_b (
    .clk(clk), .reset(reset), .exc_req(b_req), .pc_in(b_pc),
    .mem_data_in(b_mdata), .mem_addr(b_maddr), .mem_read(b_mrd),
    .epc_write(b_epcw), .epc_data(b_epcd), .pc_write(b_pcw),
    .pc_out(b_pco), .cause_out(b_cause), .busy(b_busy), .done(b_done)
  );

  function automatic logic [7:0] memrd(input logic [31:0] a);
    case (a)
      32'd253: return 8'h11;
      32'd254: return 8'h7C;
      32'd255: return 8'hC3;
      32'h104: return 8'hA5;
      default: return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Memory returns valid data only once the read has been held for the latency.
  always @(posedge clk) begin
    rd_cnt_a <= (reset || !mem_read) ? 0 : rd_cnt_a + 1;
    rd_cnt_b <= (reset || !b_mrd) ? 0 : rd_cnt_b + 1;
  end
  assign mem_data_in = (mem_read && rd_cnt_a == L_A - 1) ? memrd(mem_addr) : 8'hEE;
  assign b_mdata     = (b_mrd && rd_cnt_b == L_B - 1) ? memrd(b_maddr) : 8'hEE;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a service starts at offset 0 in an idle cycle and its
  // outputs follow from the offset since that start.
  logic       m_act;
  int         m_k;
  logic [2:0] m_pend;
  logic [1:0] m_cause;

  function automatic logic [1:0] lowest(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_act = 1'b0; m_k = 0; m_pend = '0; m_cause = '0;
  endtask

  task automatic cyc(input logic [2:0] r, input logic [31:0] pc);
    logic [2:0] any;
    logic       rd;
    @(negedge clk);
    exc_req = r;
    pc_in   = pc;
    #1;
    rd = m_act && m_k >= 2 && m_k <= 1 + L_A;
    chk("epc_write", 32'(epc_write), 32'(m_act && m_k == 1));
    chk("epc_data",  epc_data, (m_act && m_k == 1) ? pc - 32'd4 : 32'd0);
    chk("mem_read",  32'(mem_read), 32'(rd));
    chk("mem_addr",  mem_addr, rd ? 32'(VB_A) + 32'(m_cause) : 32'd0);
    chk("pc_write",  32'(pc_write), 32'(m_act && m_k == 2 + L_A));
    chk("pc_out",    pc_out, (m_act && m_k == 2 + L_A) ?
                             32'(memrd(32'(VB_A) + 32'(m_cause))) : 32'd0);
    chk("done",      32'(done), 32'(m_act && m_k == 3 + L_A));
    chk("busy",      32'(busy), 32'(m_act));
    chk("cause_out", 32'(cause_out), 32'(m_cause));
    if (m_act) begin
      if (m_k == 1) m_pend = (m_pend & ~(3'b001 << m_cause)) | r;
      else          m_pend = m_pend | r;
      if (m_k == 3 + L_A) m_act = 1'b0;
      else                m_k++;
    end else begin
      any    = m_pend | r;
      m_pend = any;
      if (any != 0) begin
        m_cause = lowest(any);
        m_act   = 1'b1;
        m_k     = 1;
      end
    end
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_read"}, 32'(mem_read), 0);
    chk({tag, "_epc_write"}, 32'(epc_write), 0);
    chk({tag, "_epc_data"}, epc_data, 0);
    chk({tag, "_pc_write"}, 32'(pc_write), 0);
    chk({tag, "_pc_out"}, pc_out, 0);
    chk({tag, "_cause_out"}, 32'(cause_out), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [31:0] pc;
    logic        ew;
    logic [31:0] ed;
    logic        mr;
    logic [31:0] ma;
    logic        pw;
    logic [31:0] po;
    logic        dn;
    logic        bz;
    logic [1:0]  co;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [2:0] r;
    tbl[0] = '{3'b010, 32'h40, 0, 32'h0,  0, 32'd0,   0, 32'h0,  0, 0, 2'd0};
    tbl[1] = '{3'b000, 32'h40, 1, 32'h3C, 0, 32'd0,   0, 32'h0,  0, 1, 2'd1};
    tbl[2] = '{3'b000, 32'h40, 0, 32'h0,  1, 32'd254, 0, 32'h0,  0, 1, 2'd1};
    tbl[3] = '{3'b000, 32'h40, 0, 32'h0,  1, 32'd254, 0, 32'h0,  0, 1, 2'd1};
    tbl[4] = '{3'b000, 32'h40, 0, 32'h0,  0, 32'd0,   1, 32'h7C, 0, 1, 2'd1};
    tbl[5] = '{3'b000, 32'h40, 0, 32'h0,  0, 32'd0,   0, 32'h0,  1, 1, 2'd1};
    tbl[6] = '{3'b000, 32'h40, 0, 32'h0,  0, 32'd0,   0, 32'h0,  0, 0, 2'd1};

    reset = 1'b1; exc_req = '0; pc_in = '0; b_req = '0; b_pc = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk_zero_a("reset");
    chk("reset_b_busy", 32'(b_busy), 0);
    chk("reset_b_cause", 32'(b_cause), 0);
    reset = 1'b0;

    // Single overflow exception against the directed table
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].req, tbl[i].pc);
      chk("t_epc_write", 32'(epc_write), 32'(tbl[i].ew));
      chk("t_epc_data", epc_data, tbl[i].ed);
      chk("t_mem_read", 32'(mem_read), 32'(tbl[i].mr));
      chk("t_mem_addr", mem_addr, tbl[i].ma);
      chk("t_pc_write", 32'(pc_write), 32'(tbl[i].pw));
      chk("t_pc_out", pc_out, tbl[i].po);
      chk("t_done", 32'(done), 32'(tbl[i].dn));
      chk("t_busy", 32'(busy), 32'(tbl[i].bz));
      chk("t_cause", 32'(cause_out), 32'(tbl[i].co));
    end

    // Two simultaneous causes, then a higher-priority request during a read
    cyc(3'b110, 32'h100);
    repeat (14) cyc(3'b000, 32'h200);
    cyc(3'b100, 32'h300);
    cyc(3'b000, 32'h300);
    cyc(3'b000, 32'h300);
    cyc(3'b001, 32'h304);
    repeat (14) cyc(3'b000, 32'h400);

    // Reset in the second read cycle with another cause still pending
    cyc(3'b110, 32'h500);
    cyc(3'b000, 32'h500);
    cyc(3'b000, 32'h500);
    @(negedge clk);
    reset = 1'b1; exc_req = '0;
    #1;
    chk("rst_mid_pc_write", 32'(pc_write), 0);
    @(negedge clk);
    #1;
    chk_zero_a("rst_mid");
    reset = 1'b0;
    model_reset();
    repeat (6) cyc(3'b000, 32'h600);

    // Random requests against the model
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      cyc(r, {$urandom} & 32'hFFFF_FFFC);
    end
    repeat (30) cyc(3'b000, 32'h0);

    // Five causes, base 0x100, latency 4: cause 4 only
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      b_req = (c == 0) ? 5'b10000 : 5'b00000;
      b_pc  = 32'h200;
      #1;
      chk("b_busy", 32'(b_busy), 32'(c >= 1 && c <= 7));
      chk("b_epc_write", 32'(b_epcw), 32'(c == 1));
      chk("b_epc_data", b_epcd, (c == 1) ? 32'h1FC : 32'h0);
      chk("b_mem_read", 32'(b_mrd), 32'(c >= 2 && c <= 5));
      chk("b_mem_addr", b_maddr, (c >= 2 && c <= 5) ? 32'h104 : 32'h0);
      chk("b_pc_write", 32'(b_pcw), 32'(c == 6));
      chk("b_pc_out", b_pco, (c == 6) ? 32'hA5 : 32'h0);
      chk("b_done", 32'(b_done), 32'(c == 7));
      chk("b_cause", 32'(b_cause), (c >= 1) ? 32'd4 : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
